// File: rtl/onehot_decoder_pkg.sv
// Shared types and widths for the one-hot decoder and its entry buffer.
package onehot_decoder_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned OUT_W  = 8;

  // One buffered entry: decoder enable plus the binary code.
  typedef struct packed {
    logic              en;
    logic [CODE_W-1:0] code;
  } entry_t;

  // One-hot decode of a stored entry; a disabled entry decodes to zero.
  function automatic logic [OUT_W-1:0] decode(input entry_t e);
    logic [OUT_W-1:0] word;
    word = '0;
    if (e.en) begin
      word = OUT_W'(1) << e.code;
    end
    return word;
  endfunction

endpackage

// File: rtl/onehot_fifo.sv
// Valid/ready FIFO of DEPTH entries; pointers wrap modulo DEPTH.
module onehot_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = logic [3:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  entry_t                   push_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output entry_t                   pop_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic          push;
  logic          pop;

  // Ready looks only at stored level, so a pop never opens a same-cycle slot.
  assign push_ready = rst_n && (level_q != LW'(DEPTH));
  assign pop_valid  = (level_q != '0);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign pop_data   = mem_q[rd_ptr_q];
  assign level      = level_q;

  // Next-state: storage write, pointer advance and occupancy update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage; contents are don't-care while level excludes them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/onehot_decoder.sv
// Buffered 3-to-8 one-hot decoder; decode sits on the registered FIFO head.
module onehot_decoder
  import onehot_decoder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_code,
  input  logic                   in_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_d,
  output logic [$clog2(DEPTH):0] level
);

  entry_t in_entry;
  entry_t head;

  assign in_entry.en   = in_en;
  assign in_entry.code = in_code;

  onehot_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (in_entry),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head),
    .level      (level)
  );

  // Output word is forced to zero whenever nothing is presented.
  always_comb begin
    out_d = '0;
    if (out_valid) begin
      out_d = decode(head);
    end
  end

endmodule

// File: tb/tb_onehot_decoder.sv
// Self-checking bench for onehot_decoder (DEPTH=4).
module tb_onehot_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic       in_en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_d;
  logic [2:0] level;

  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          mon_en = 0;
  logic [7:0]  sb_q[$];

  onehot_decoder #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_en     (in_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d     (out_d),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference word for a code/enable pair: single set bit, or zero when disabled.
  function automatic logic [7:0] model_word(input logic [2:0] code, input logic en);
    logic [7:0] w;
    w = 8'h00;
    if (en) w[code] = 1'b1;
    return w;
  endfunction

  // Scoreboard: handshakes seen mid-cycle commit at the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("level_model", {29'd0, level}, sb_q.size());
      chk("out_valid_model", {31'd0, out_valid}, (sb_q.size() != 0) ? 1 : 0);
      if (!out_valid) chk("idle_out_d", {24'd0, out_d}, 0);
      if (!rst_n) begin
        chk("ready_in_reset", {31'd0, in_ready}, 0);
        sb_q.delete();
      end else begin
        chk("in_ready_model", {31'd0, in_ready}, (sb_q.size() != 4) ? 1 : 0);
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            chk("pop_underflow", 1, 0);
          end else begin
            chk("order", {24'd0, out_d}, {24'd0, sb_q.pop_front()});
          end
        end
        if (in_valid && in_ready) sb_q.push_back(model_word(in_code, in_en));
      end
    end
  end

  typedef struct {
    logic [2:0] code;
    logic       en;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[9];

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain_done", sb_q.size(), 0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl[i].code = 3'(i);
      tbl[i].en   = 1'b1;
      tbl[i].exp  = 8'h01 << i;
    end
    tbl[8].code = 3'd5;
    tbl[8].en   = 1'b0;
    tbl[8].exp  = 8'h00;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_code   = 3'd1;
    in_en     = 1'b1;
    out_ready = 1'b1;
    step();
    mon_en = 1;
    step();
    @(negedge clk);
    chk("reset_level", {29'd0, level}, 0);
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_out_d", {24'd0, out_d}, 0);
    chk("reset_in_ready", {31'd0, in_ready}, 0);
    step();
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Codes 0..7 enabled, then code 5 disabled; each visible one cycle after push.
    for (int i = 0; i < 9; i++) begin
      step();
      in_valid = 1'b1;
      in_code  = tbl[i].code;
      in_en    = tbl[i].en;
      @(negedge clk);
      chk("tbl_accept", {31'd0, in_ready}, 1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("tbl_valid", {31'd0, out_valid}, 1);
      chk("tbl_out_d", {24'd0, out_d}, {24'd0, tbl[i].exp});
    end
    step();

    // Fill to full with output stalled; fifth code must wait.
    out_ready = 1'b0;
    in_en     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_code  = 3'(i + 3);
      @(negedge clk);
      chk("fill_accept", {31'd0, in_ready}, 1);
      step();
    end
    in_code = 3'd7;
    @(negedge clk);
    chk("full_level", {29'd0, level}, 4);
    chk("full_in_ready", {31'd0, in_ready}, 0);
    step();
    @(negedge clk);
    chk("full_hold", {31'd0, in_ready}, 0);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("no_bypass", {31'd0, in_ready}, 0);
    step();
    @(negedge clk);
    chk("ready_after_pop", {31'd0, in_ready}, 1);
    step();
    in_valid = 1'b0;
    drain();

    // Steady state at level 2 with push and pop every cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_code = 3'(i);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_code = 3'(i + 2);
      @(negedge clk);
      chk("steady_level", {29'd0, level}, 2);
      step();
    end
    in_valid = 1'b0;
    drain();

    // Mid-operation reset discards three buffered words.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_code = 3'(i + 5);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_level", {29'd0, level}, 3);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_level", {29'd0, level}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_d", {24'd0, out_d}, 0);
    step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code   = 3'd2;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_word", {24'd0, out_d}, 32'h04);
    step();
    @(negedge clk);
    chk("post_rst_empty", {31'd0, out_valid}, 0);
    step();

    // Stalled output stays stable while inputs wiggle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 3'd3;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_code = 3'(i * 3 + 1);
      in_en   = i[0];
      @(negedge clk);
      chk("stall_out_d", {24'd0, out_d}, 32'h08);
      chk("stall_valid", {31'd0, out_valid}, 1);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
